// File: rtl/bus_pkg.sv
// bus_pkg: shared bus geometry and source index constants for the single-bus datapath.
package bus_pkg;
   localparam int BUS_WIDTH  = 32;
   localparam int BUS_NSRC   = 32;
   localparam int SRC_R0     = 0;
   localparam int SRC_R1     = 1;
   localparam int SRC_R2     = 2;
   localparam int SRC_R3     = 3;
   localparam int SRC_R4     = 4;
   localparam int SRC_R5     = 5;
   localparam int SRC_R6     = 6;
   localparam int SRC_R7     = 7;
   localparam int SRC_R8     = 8;
   localparam int SRC_R9     = 9;
   localparam int SRC_R10    = 10;
   localparam int SRC_R11    = 11;
   localparam int SRC_R12    = 12;
   localparam int SRC_R13    = 13;
   localparam int SRC_R14    = 14;
   localparam int SRC_R15    = 15;
   localparam int SRC_HI     = 16;
   localparam int SRC_LO     = 17;
   localparam int SRC_ZHI    = 18;
   localparam int SRC_ZLO    = 19;
   localparam int SRC_PC     = 20;
   localparam int SRC_MDR    = 21;
   localparam int SRC_INPORT = 22;
   localparam int SRC_C      = 23;
endpackage

// File: rtl/bus_prio_enc.sv
// bus_prio_enc: lowest-index priority encoder over drive enables, with any/multi flags.
module bus_prio_enc #(
   parameter int N_SRC = 32,
   parameter int IDX_W = $clog2(N_SRC)
) (
   input  logic [N_SRC-1:0] i_req,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any,
   output logic             o_multi
);
   always_comb begin
      o_idx = '0;
      for (int k = N_SRC - 1; k >= 0; k--)
         if (i_req[k]) o_idx = IDX_W'(k);
   end
   assign o_any   = |i_req;
   // clearing the lowest set bit leaves something only if two or more were set
   assign o_multi = |(i_req & (i_req - N_SRC'(1)));
endmodule

// File: rtl/bus_select_reg.sv
// bus_select_reg: registered N-source bus mux with bus keeper and sticky conflict detect.
// Define BUS_CONFLICT_COUNT_EN to add the saturating conflict_count output.
module bus_select_reg
   import bus_pkg::*;
#(
   parameter int N_SRC = BUS_NSRC,
   parameter int WIDTH = BUS_WIDTH,
   localparam int IDX_W = $clog2(N_SRC)
) (
   input  logic                   clock,
   input  logic                   clear,
   input  logic [N_SRC*WIDTH-1:0] bus_in,
   input  logic [N_SRC-1:0]       drive_en,
   input  logic                   conflict_clr,
   output logic [WIDTH-1:0]       bus_out,
   output logic                   bus_valid,
   output logic [IDX_W-1:0]       owner_idx,
   output logic                   conflict,
`ifdef BUS_CONFLICT_COUNT_EN
   output logic [15:0]            conflict_count,
`endif
   output logic [N_SRC-1:0]       conflict_mask
);
   logic [IDX_W-1:0] w_idx;
   logic             w_any;
   logic             w_multi;
   logic [WIDTH-1:0] r_bus;
   logic             r_valid;
   logic [IDX_W-1:0] r_owner;
   logic             r_conf;
   logic [N_SRC-1:0] r_mask;

   bus_prio_enc #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_enc (
      .i_req   (drive_en),
      .o_idx   (w_idx),
      .o_any   (w_any),
      .o_multi (w_multi)
   );

   always_ff @(posedge clock) begin
      if (clear) begin
         r_bus   <= '0;
         r_valid <= 1'b0;
         r_owner <= '0;
         r_conf  <= 1'b0;
         r_mask  <= '0;
      end else begin
         r_valid <= w_any;
         if (w_any) begin
            r_bus   <= bus_in[w_idx*WIDTH +: WIDTH];
            r_owner <= w_idx;
         end
         // a conflict in the same cycle as conflict_clr starts a fresh capture
         if (w_multi) begin
            r_conf <= 1'b1;
            if (!r_conf || conflict_clr) r_mask <= drive_en;
         end else if (conflict_clr) begin
            r_conf <= 1'b0;
            r_mask <= '0;
         end
      end
   end

`ifdef BUS_CONFLICT_COUNT_EN
   logic [15:0] r_cnt;
   always_ff @(posedge clock) begin
      if (clear) r_cnt <= '0;
      else if (w_multi) r_cnt <= conflict_clr ? 16'd1 : (&r_cnt ? r_cnt : r_cnt + 16'd1);
      else if (conflict_clr) r_cnt <= '0;
   end
   assign conflict_count = r_cnt;
`endif

   assign bus_out       = r_bus;
   assign bus_valid     = r_valid;
   assign owner_idx     = r_owner;
   assign conflict      = r_conf;
   assign conflict_mask = r_mask;
endmodule

// File: tb/tb_bus_select_reg.sv
// tb_bus_select_reg: directed and random stimulus checked against a behavioural bus model.
module tb_bus_select_reg;
   import bus_pkg::*;
   localparam int N = BUS_NSRC;
   localparam int W = BUS_WIDTH;

   logic             clock = 1'b0;
   logic             clear;
   logic [N*W-1:0]   bus_in;
   logic [N-1:0]     drive_en;
   logic             conflict_clr;
   logic [W-1:0]     bus_out;
   logic             bus_valid;
   logic [4:0]       owner_idx;
   logic             conflict;
   logic [N-1:0]     conflict_mask;
`ifdef BUS_CONFLICT_COUNT_EN
   logic [15:0]      conflict_count;
`endif

   int checks = 0;
   int failures = 0;

   logic [W-1:0] m_bus;
   logic         m_valid;
   int           m_owner;
   logic         m_conf;
   logic [N-1:0] m_mask;
   int           m_cnt;

   bus_select_reg dut (
      .clock         (clock),
      .clear         (clear),
      .bus_in        (bus_in),
      .drive_en      (drive_en),
      .conflict_clr  (conflict_clr),
      .bus_out       (bus_out),
      .bus_valid     (bus_valid),
      .owner_idx     (owner_idx),
      .conflict      (conflict),
`ifdef BUS_CONFLICT_COUNT_EN
      .conflict_count(conflict_count),
`endif
      .conflict_mask (conflict_mask)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // next-state of the bus as described behaviourally, from the inputs present at the edge
   task automatic model;
      int n;
      logic [N-1:0] low;
      n = $countones(drive_en);
      if (clear) begin
         m_bus = '0; m_valid = 0; m_owner = 0; m_conf = 0; m_mask = '0; m_cnt = 0;
         return;
      end
      m_valid = (n > 0);
      if (n > 0) begin
         low = drive_en & (~drive_en + 1'b1);
         m_owner = $clog2(low);
         m_bus = bus_in[m_owner*W +: W];
      end
      if (n >= 2) begin
         if (!m_conf || conflict_clr) m_mask = drive_en;
         m_conf = 1;
         m_cnt = conflict_clr ? 1 : (m_cnt < 65535 ? m_cnt + 1 : 65535);
      end else if (conflict_clr) begin
         m_conf = 0; m_mask = '0; m_cnt = 0;
      end
   endtask

   task automatic step(input string tag);
      model();
      @(posedge clock);
      #1;
      chk({tag, ".bus"}, 64'(bus_out), 64'(m_bus));
      chk({tag, ".valid"}, 64'(bus_valid), 64'(m_valid));
      chk({tag, ".owner"}, 64'(owner_idx), 64'(m_owner));
      chk({tag, ".conf"}, 64'(conflict), 64'(m_conf));
      chk({tag, ".mask"}, 64'(conflict_mask), 64'(m_mask));
`ifdef BUS_CONFLICT_COUNT_EN
      chk({tag, ".cnt"}, 64'(conflict_count), 64'(m_cnt));
`endif
   endtask

   task automatic rand_bus;
      for (int k = 0; k < N; k++) bus_in[k*W +: W] = $urandom;
   endtask

   initial begin
      m_bus = '0; m_valid = 0; m_owner = 0; m_conf = 0; m_mask = '0; m_cnt = 0;
      @(posedge clock);
      #1;
      rand_bus();
      clear = 1; drive_en = $urandom | 32'h3; conflict_clr = 1'b0;
      step("reset");
      chk("reset.bus_zero", 64'(bus_out), 64'd0);
      clear = 0;
      rand_bus();
      bus_in[SRC_R5*W +: W] = 32'hDEADBEEF;
      drive_en = 32'd1 << SRC_R5;
      step("src5");
      chk("src5.const", 64'(bus_out), 64'hDEADBEEF);
      chk("src5.owner_const", 64'(owner_idx), 64'd5);
      drive_en = '0;
      for (int i = 0; i < 3; i++) begin
         rand_bus();
         step("hold");
      end
      chk("hold.const", 64'(bus_out), 64'hDEADBEEF);
      rand_bus();
      drive_en = (32'd1 << 3) | (32'd1 << 9);
      step("conf1");
      chk("conf1.mask_const", 64'(conflict_mask), 64'h208);
      drive_en = 32'h6;
      step("conf2");
      chk("conf2.mask_const", 64'(conflict_mask), 64'h208);
      conflict_clr = 1; drive_en = 32'h8000_0000;
      step("clr31");
      chk("clr31.conf_const", 64'(conflict), 64'd0);
      drive_en = 32'h3;
      step("clrconf");
      chk("clrconf.mask_const", 64'(conflict_mask), 64'h3);
      conflict_clr = 0;
      for (int k = 0; k < N; k++) begin
         for (int j = 0; j < N; j++) bus_in[j*W +: W] = 32'(j) * 32'h01010101;
         drive_en = 32'd1 << k;
         step("sweep");
      end
      for (int i = 0; i < 400; i++) begin
         rand_bus();
         case ($urandom_range(0, 3))
            0: drive_en = '0;
            1: drive_en = 32'd1 << $urandom_range(0, N - 1);
            2: drive_en = (32'd1 << $urandom_range(0, N - 1)) | (32'd1 << $urandom_range(0, N - 1));
            default: drive_en = $urandom & $urandom;
         endcase
         conflict_clr = ($urandom_range(0, 9) == 0);
         clear = ($urandom_range(0, 49) == 0);
         step("rand");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
